imem_fetch_responder: RTL and testbench

Instruction-memory responder at the far end of the fetch interface: accepts word fetch requests driven from the program counter and returns the 32-bit instruction stored at that address. It contains the instruction store, a fixed-latency read pipeline and a response FIFO, and it enforces credit-based flow control so no response is ever dropped. It sits between the IF stage and the decode stage, and it provides a load port for programme initialisation by the bench or boot logic.

---
 rtl/imem_pkg.sv | 35 +++
 rtl/imem_rsp_fifo.sv | 76 +++++++
 rtl/imem_fetch_responder.sv | 133 +++++++++++++
 tb/tb_imem_fetch_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared types, constants and address-check helper for the
//                instruction-memory fetch responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    // Instruction returned for any fetch that cannot be served from the store
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One response as seen by the decode stage
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } rsp_t;

    // One read-pipeline stage
    typedef struct packed {
        logic valid;
        rsp_t rsp;
    } pipe_stage_t;

    // A fetch is serviceable when it is word aligned and its word index lies
    // inside the store; the full 30-bit word index is compared so that high
    // addresses never alias onto low words.
    function automatic logic fetch_addr_ok(input logic [31:0] addr,
                                           input int unsigned depth_words);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : imem_rsp_fifo
//  Description : Generic synchronous FIFO, first-word fall-through on the
//                read side (pop_data shows the head whenever not empty).
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_FULL_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers wrap explicitly so DEPTH need not be a power of two
    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_LAST_PTR) ? '0 : ptr + c_PTR_W'(1);
    endfunction

    // Storage array: data is not reset, only the bookkeeping is
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_fetch_responder.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_responder
//  Description : Instruction store with fixed-latency read pipeline, in-order
//                response FIFO and credit-based request flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS    = 1024,
    parameter int LATENCY        = 2,
    parameter int RSP_FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_instr,
    output logic [31:0]                    rsp_addr,
    output logic                           rsp_err,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [31:0]                    ld_data
);

    localparam int c_ADDR_W = $clog2(DEPTH_WORDS);
    localparam int c_CRED_W = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int c_RSP_W  = $bits(rsp_t);
    localparam logic [c_CRED_W-1:0] c_CREDIT_MAX = c_CRED_W'(RSP_FIFO_DEPTH);

    logic [31:0]         r_mem [DEPTH_WORDS];
    pipe_stage_t         r_pipe [LATENCY];
    logic [c_CRED_W-1:0] r_credit;
    rsp_t                r_last;

    logic                w_accept;
    logic                w_pop;
    logic                w_push;
    logic                w_addr_ok;
    logic [c_ADDR_W-1:0] w_rd_idx;
    rsp_t                w_head;
    rsp_t                w_rsp;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [c_CRED_W-1:0] w_fifo_count;

    // Credits cover in-flight plus queued responses, so a full count means the
    // FIFO could not absorb one more; no pop bypass keeps req_ready registered.
    assign req_ready = (r_credit < c_CREDIT_MAX);
    assign w_accept  = req_valid && req_ready;
    assign w_addr_ok = fetch_addr_ok(req_addr, DEPTH_WORDS);
    assign w_rd_idx  = req_addr[c_ADDR_W+1:2];

    assign rsp_valid = (w_fifo_count != '0);
    assign w_pop     = rsp_valid && rsp_ready;
    assign w_push    = r_pipe[LATENCY-1].valid && !w_fifo_full;

    // When the FIFO drains the outputs keep showing the last delivered response
    assign w_rsp     = w_fifo_empty ? r_last : w_head;
    assign rsp_instr = w_rsp.instr;
    assign rsp_addr  = w_rsp.addr;
    assign rsp_err   = w_rsp.err;

    // Load port; non-blocking update gives read-before-write against stage 1
    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    // Read pipeline: stage 0 checks the address and reads the store, later
    // stages just delay the result so every response has the same latency
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0].valid <= w_accept;
            if (w_accept) begin
                r_pipe[0].rsp.addr  <= req_addr;
                r_pipe[0].rsp.err   <= !w_addr_ok;
                r_pipe[0].rsp.instr <= w_addr_ok ? r_mem[w_rd_idx] : NOP_INSTR;
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Credit counter: +1 per accept, -1 per pop, unchanged when both occur
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_credit <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_credit <= r_credit + c_CRED_W'(1);
                2'b01:   r_credit <= r_credit - c_CRED_W'(1);
                default: r_credit <= r_credit;
            endcase
        end
    end

    // Remember the most recently delivered response for the empty case
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last <= '0;
        end else if (w_pop) begin
            r_last <= w_head;
        end
    end

    imem_rsp_fifo #(
        .DEPTH (RSP_FIFO_DEPTH),
        .WIDTH (c_RSP_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (w_push),
        .push_data (r_pipe[LATENCY-1].rsp),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_fetch_responder
//  Description : Directed and scoreboarded bench for imem_fetch_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_responder;
    import imem_pkg::*;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    int n_checks  = 0;
    int n_errors  = 0;

    // scoreboard state
    logic        sb_on = 1'b0;
    rsp_t        exp_q [$];
    logic [31:0] model_mem [64];
    int          n_popped    = 0;
    int          outstanding = 0;
    int          max_out     = 0;

    imem_fetch_responder #(
        .DEPTH_WORDS    (1024),
        .LATENCY        (2),
        .RSP_FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = 10'(idx);
        ld_data = data;
        step();
        ld_en   = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 20 && !rsp_valid; i++) step();
        check(tag, 32'(rsp_valid), 32'd1);
    endtask

    task automatic single_fetch(input string tag, input logic [31:0] addr,
                                input logic [31:0] exp_instr, input logic exp_err);
        req_valid = 1'b1;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
        wait_rsp({tag, "_valid"});
        check({tag, "_instr"}, rsp_instr, exp_instr);
        check({tag, "_addr"},  rsp_addr,  addr);
        check({tag, "_err"},   32'(rsp_err), 32'(exp_err));
        step();
    endtask

    // Scoreboard: inputs only change just after rising edges, so the values
    // seen at the falling edge are the ones the next rising edge will act on.
    always @(negedge clk) begin
        if (sb_on && rstn) begin
            if (req_valid && req_ready) begin
                exp_q.push_back('{addr: req_addr, instr: model_mem[req_addr[7:2]], err: 1'b0});
                outstanding++;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    check("sb_instr", rsp_instr, e.instr);
                    check("sb_addr",  rsp_addr,  e.addr);
                    check("sb_err",   32'(rsp_err), 32'd0);
                end
                n_popped++;
                outstanding--;
            end
            if (outstanding > max_out) max_out = outstanding;
        end
    end

    initial begin
        logic [31:0] exp_bp [4];
        int          acc;
        int          issued;
        int          cyc;

        rstn = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        exp_bp[0] = 32'h11; exp_bp[1] = 32'h22; exp_bp[2] = 32'h33; exp_bp[3] = 32'h44;

        // reset state
        step(); step();
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_instr", rsp_instr, 32'd0);
        check("rst_addr",  rsp_addr,  32'd0);
        check("rst_err",   32'(rsp_err), 32'd0);
        rstn = 1'b1;
        step();
        check("rst_ready", 32'(req_ready), 32'd1);

        load(0, 32'h11); load(1, 32'h22); load(2, 32'h33); load(3, 32'h44);
        load(5, 32'h55);

        // back-to-back in-range fetches, latency and ordering
        req_valid = 1'b1; req_addr = 32'd0;
        step(); req_addr = 32'd4;  check("lat_e0", 32'(rsp_valid), 32'd0);
        step(); req_addr = 32'd8;  check("lat_e1", 32'(rsp_valid), 32'd0);
        step(); req_addr = 32'd12;
        check("b2b_v0", 32'(rsp_valid), 32'd1);
        check("b2b_i0", rsp_instr, 32'h11);
        check("b2b_a0", rsp_addr, 32'd0);
        check("b2b_e0", 32'(rsp_err), 32'd0);
        step(); req_valid = 1'b0;
        check("b2b_i1", rsp_instr, 32'h22); check("b2b_a1", rsp_addr, 32'd4);
        step();
        check("b2b_i2", rsp_instr, 32'h33); check("b2b_a2", rsp_addr, 32'd8);
        step();
        check("b2b_i3", rsp_instr, 32'h44); check("b2b_e3", 32'(rsp_err), 32'd0);
        step();
        check("empty_valid", 32'(rsp_valid), 32'd0);
        check("empty_hold",  rsp_instr, 32'h44);

        // error responses: misaligned, just past the store, top of address space
        req_valid = 1'b1; req_addr = 32'h2;
        step(); req_addr = 32'h1000;
        step(); req_addr = 32'hFFFF_FFFC;
        step(); req_valid = 1'b0;
        check("err_mis_i", rsp_instr, NOP_INSTR);
        check("err_mis_e", 32'(rsp_err), 32'd1);
        check("err_mis_a", rsp_addr, 32'h2);
        step();
        check("err_oor_i", rsp_instr, NOP_INSTR);
        check("err_oor_e", 32'(rsp_err), 32'd1);
        check("err_oor_a", rsp_addr, 32'h1000);
        step();
        check("err_wrap_i", rsp_instr, NOP_INSTR);
        check("err_wrap_e", 32'(rsp_err), 32'd1);
        check("err_wrap_a", rsp_addr, 32'hFFFF_FFFC);
        step();

        // backpressure: exactly four accepts, then ready drops
        rsp_ready = 1'b0; req_valid = 1'b1; acc = 0;
        for (int i = 0; i < 8; i++) begin
            logic will;
            req_addr = 32'(acc * 4);
            will = req_ready;
            step();
            if (will) acc++;
        end
        req_valid = 1'b0;
        check("bp_accepts", 32'(acc), 32'd4);
        check("bp_ready",   32'(req_ready), 32'd0);
        check("bp_hold_v",  32'(rsp_valid), 32'd1);
        check("bp_hold_i",  rsp_instr, 32'h11);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_drain_v", 32'(rsp_valid), 32'd1);
            check("bp_drain_i", rsp_instr, exp_bp[k]);
            step();
            if (k == 0) check("full_pop_ready", 32'(req_ready), 32'd1);
        end
        check("bp_done_v", 32'(rsp_valid), 32'd0);

        // read-before-write on the same word
        ld_en = 1'b1; ld_addr = 10'd5; ld_data = 32'hAB;
        req_valid = 1'b1; req_addr = 32'd20;
        step();
        ld_en = 1'b0; req_valid = 1'b0;
        wait_rsp("rbw_valid");
        check("rbw_old", rsp_instr, 32'h55);
        step();
        single_fetch("rbw_new", 32'd20, 32'hAB, 1'b0);

        // reset with two in flight and two queued
        rsp_ready = 1'b0; req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_addr = 32'(k * 4);
            step();
        end
        req_valid = 1'b0;
        check("mid_pre_v", 32'(rsp_valid), 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_v", 32'(rsp_valid), 32'd0);
        check("mid_rst_i", rsp_instr, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        check("mid_ready", 32'(req_ready), 32'd1);
        step(); step(); step();
        check("mid_noghost", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b1;
        single_fetch("mid_fetch", 32'd8, 32'h33, 1'b0);

        // random traffic against the scoreboard
        for (int i = 0; i < 64; i++) begin
            model_mem[i] = $urandom;
            load(i, model_mem[i]);
        end
        sb_on = 1'b1; issued = 0; cyc = 0;
        while (issued < 1000 && cyc < 20000) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = 32'($urandom_range(0, 63)) << 2;
            rsp_ready = ($urandom_range(0, 1) == 1);
            if (req_valid && req_ready) issued++;
            step();
            cyc++;
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        sb_on = 1'b0;
        check("rnd_issued", 32'(issued), 32'd1000);
        check("rnd_drain",  32'(exp_q.size()), 32'd0);
        check("rnd_count",  32'(n_popped), 32'(issued));
        check("rnd_credit", 32'(max_out <= 4), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
